alu_issue_ctrl: RTL

- Two-requester round-robin scheduler that shares the single execute unit (top_dut) between requesters.
- Accepts one operation per grant, captures its operands, and drives enable_ex, control_in, src1, src2 and imm into the execute unit.
- Waits the fixed ALU latency, or for memory read data on MEM_READ operations, then returns aluout and carry to the granted requester through a valid/ready response channel.

---
 rtl/alu_issue_pkg.sv | 25 ++
 rtl/alu_issue_ctrl_if.sv | 43 ++++
 rtl/rr_arb2.sv | 20 ++
 rtl/alu_issue_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types, control-word layout and class codes for the ALU issue controller
package alu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MEM_WAIT = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam int CTRL_W      = 7;
    localparam int FUNC_LSB    = 0;
    localparam int CLASS_LSB   = 3;
    localparam int IMM_SEL_BIT = 6;

    localparam logic [2:0] CLS_SHIFT     = 3'b000;
    localparam logic [2:0] CLS_ARITH     = 3'b001;
    localparam logic [2:0] CLS_MEM_WRITE = 3'b100;
    localparam logic [2:0] CLS_MEM_READ  = 3'b101;

    function automatic logic is_mem_read(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CLASS_LSB +: 3] == CLS_MEM_READ;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - requester, execute-unit and response signals of the ALU issue controller
interface alu_issue_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 7
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][CTRL_W-1:0] req_ctrl;
    logic [1:0][DATA_W-1:0] req_src1;
    logic [1:0][DATA_W-1:0] req_src2;
    logic [1:0][DATA_W-1:0] req_imm;

    logic                   enable_ex;
    logic [CTRL_W-1:0]      control_in;
    logic [DATA_W-1:0]      src1;
    logic [DATA_W-1:0]      src2;
    logic [DATA_W-1:0]      imm;
    logic [DATA_W-1:0]      aluout;
    logic                   carry;
    logic                   mem_rd_valid;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_carry;
    logic                   rsp_err;

    // master = the issue controller, slave = requesters plus execute unit
    modport master (
        input  req_valid, req_ctrl, req_src1, req_src2, req_imm,
        input  aluout, carry, mem_rd_valid, rsp_ready,
        output req_ready, enable_ex, control_in, src1, src2, imm,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
    );

    modport slave (
        output req_valid, req_ctrl, req_src1, req_src2, req_imm,
        output aluout, carry, mem_rd_valid, rsp_ready,
        input  req_ready, enable_ex, control_in, src1, src2, imm,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_err
    );
endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin grant; the parent holds last_grant
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_idx
);
    logic other;

    assign other = ~last_grant;

    always_comb begin
        gnt_idx = req[other] ? other : last_grant;
        gnt     = 2'b00;
        if (en && req[gnt_idx]) begin
            gnt[gnt_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - round-robin issue of two requesters onto one ALU with registered responses
// Optional performance counters (perf_ops, perf_stall) are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int EX_LATENCY  = 1,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    alu_issue_ctrl_if.master bus
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_stall
`endif
);
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              last_q;
    logic              gid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] src1_q, src2_q, imm_q;

    logic              rsp_valid_q, rsp_id_q, rsp_carry_q, rsp_err_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic [1:0]        gnt;
    logic              gnt_idx;
    logic              arb_en;
    logic              load_op, load_rsp, timeout;

    assign arb_en = (state_q == IDLE);

    rr_arb2 u_arb (
        .req        (bus.req_valid),
        .last_grant (last_q),
        .en         (arb_en),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    // cnt_q is shared: ALU latency in EXEC, timeout count in MEM_WAIT
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load_op  = 1'b0;
        load_rsp = 1'b0;
        timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    load_op = 1'b1;
                    cnt_d   = '0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == 8'(EX_LATENCY - 1)) begin
                    cnt_d = '0;
                    if (is_mem_read(ctrl_q)) begin
                        state_d = MEM_WAIT;
                    end else begin
                        load_rsp = 1'b1;
                        state_d  = RESP;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MEM_WAIT: begin
                if (bus.mem_rd_valid) begin
                    load_rsp = 1'b1;
                    state_d  = RESP;
                end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
                    load_rsp = 1'b1;
                    timeout  = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b1;
            gid_q       <= 1'b0;
            ctrl_q      <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= (state_d == RESP);
            if (load_op) begin
                last_q <= gnt_idx;
                gid_q  <= gnt_idx;
                ctrl_q <= bus.req_ctrl[gnt_idx];
                src1_q <= bus.req_src1[gnt_idx];
                src2_q <= bus.req_src2[gnt_idx];
                imm_q  <= bus.req_imm[gnt_idx];
            end
            if (load_rsp) begin
                rsp_id_q    <= gid_q;
                rsp_data_q  <= timeout ? '0 : bus.aluout;
                rsp_carry_q <= timeout ? 1'b0 : bus.carry;
                rsp_err_q   <= timeout;
            end
        end
    end

    assign bus.req_ready  = gnt;
    assign bus.enable_ex  = (state_q == EXEC) && (cnt_q == 8'd0);
    assign bus.control_in = ctrl_q;
    assign bus.src1       = src1_q;
    assign bus.src2       = src2_q;
    assign bus.imm        = imm_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_err    = rsp_err_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops_q, perf_stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (rsp_valid_q && bus.rsp_ready) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if ((|bus.req_valid) && !(|gnt)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif
endmodule
